// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
// Defaults here are used as the parameter defaults of the top level.
package clk_div_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int DIV_DEFAULT_DEF = 25;
    localparam int DIV_MIN         = 2;

    // Reason a divisor load was accepted or rejected.
    typedef enum logic [0:0] {
        CFG_OK            = 1'b0,
        CFG_DIV_TOO_SMALL = 1'b1
    } cfg_cause_e;

endpackage

// File: rtl/clk_div_cfg.sv
// Divisor configuration: shadow register, pending flag, load validation and
// the hand-off of the shadow into the active divisor at a period boundary.
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             wrap,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic [CNT_W-1:0] n_act,
    output logic             pend,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] DIV_DEF_W = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_MIN);

    logic [CNT_W-1:0] shadow;
    cfg_cause_e       cause;

    always_comb begin
        cause = CFG_OK;
        if (div_val < DIV_MIN_W)
            cause = CFG_DIV_TOO_SMALL;
    end

    // A load landing on the apply edge wins the pend flag: the old shadow is
    // applied and the new value waits for the next boundary.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            shadow  <= DIV_DEF_W;
            n_act   <= DIV_DEF_W;
            pend    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= div_load && (cause == CFG_DIV_TOO_SMALL);
            if (wrap || !en) begin
                n_act <= shadow;
                pend  <= 1'b0;
            end
            if (div_load && (cause == CFG_OK)) begin
                shadow <= div_val;
                pend   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider with clk_in-domain rise/fall
// strobes. Odd divisors stretch the high phase by half a cycle via a negedge flop.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             pend,
    output logic             cfg_err
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] half;
    logic             run;
    logic             wrap;
    logic             q_p;
    logic             q_n;

    clk_div_cfg #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_cfg (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .wrap     (wrap),
        .div_val  (div_val),
        .div_load (div_load),
        .n_act    (n_act),
        .pend     (pend),
        .cfg_err  (cfg_err)
    );

    assign half = n_act >> 1;
    assign wrap = en && run && (count == n_act - 1'b1);

    // run marks that the previous cycle was enabled; without it the first
    // enabled edge would start at count 1 instead of a fresh period.
    always_comb begin
        cnt_nxt = '0;
        if (en && run && !wrap)
            cnt_nxt = count + 1'b1;
    end

    // Phase flop and ticks are computed from the next count so they line up
    // with the cycle that count describes. At a wrap cnt_nxt is 0, which is
    // below half and never equal to it for any legal divisor, old or new.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count     <= '0;
            run       <= 1'b0;
            q_p       <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            count     <= cnt_nxt;
            run       <= en;
            q_p       <= en && (cnt_nxt < half);
            rise_tick <= en && (cnt_nxt == '0);
            fall_tick <= en && (cnt_nxt == half);
        end
    end

    always_ff @(negedge clk_in or posedge rst) begin
        if (rst)
            q_n <= 1'b0;
        else
            q_n <= q_p;
    end

    // Mode select changes only at a period start, when both phase flops are low.
    assign clk_out = n_act[0] ? (q_p | q_n) : q_p;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a half-cycle reference model pushes expected
// outputs per clk_in cycle to a scoreboard that is checked after each edge.
module tb_clk_div_prog;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] div_val;
    logic        div_load;
    logic        clk_out;
    logic        rise_tick;
    logic        fall_tick;
    logic        pend;
    logic        cfg_err;

    always #5 clk_in = ~clk_in;

    clk_div_prog #(.CNT_W(16), .DIV_DEFAULT(25)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .div_val   (div_val),
        .div_load  (div_load),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .pend      (pend),
        .cfg_err   (cfg_err)
    );

    typedef struct {
        logic rise;
        logic fall;
        logic pnd;
        logic err;
        logic c0;
        logic c1;
        bit   c0_care;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: phase within the period, active/shadow divisor.
    int m_cnt, m_n, m_sh;
    bit m_run, m_pend, m_prev_en;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_n = 25; m_sh = 25;
        m_run = 0; m_pend = 0; m_prev_en = 0;
    endtask

    // clk_out is high for the first N of the 2N half-cycles of each period.
    task automatic push_expect(input bit e, input bit l, input int v);
        exp_t x;
        int   ph;
        x.err     = l && (v < 2);
        x.c0_care = 1'b1;
        if (!e) begin
            m_n = m_sh; m_pend = 0; m_run = 0; m_cnt = 0;
            x.rise = 0; x.fall = 0; x.c0 = 0; x.c1 = 0;
            x.c0_care = !m_prev_en;
        end else begin
            if (!m_run) begin
                ph = 0; m_run = 1;
            end else if (m_cnt == m_n - 1) begin
                ph = 0; m_n = m_sh; m_pend = 0;
            end else begin
                ph = m_cnt + 1;
            end
            m_cnt  = ph;
            x.rise = (ph == 0);
            x.fall = (ph == m_n / 2);
            x.c0   = (2 * ph) < m_n;
            x.c1   = (2 * ph + 1) < m_n;
        end
        if (l && v >= 2) begin
            m_sh = v; m_pend = 1;
        end
        x.pnd     = m_pend;
        m_prev_en = e;
        sbq.push_back(x);
    endtask

    task automatic step(input bit e, input bit l, input int v);
        exp_t x;
        en       = e;
        div_load = l;
        div_val  = 16'(v);
        push_expect(e, l, v);
        @(posedge clk_in);
        #2;
        x = sbq.pop_front();
        chk("rise_tick", rise_tick, x.rise);
        chk("fall_tick", fall_tick, x.fall);
        chk("pend", pend, x.pnd);
        chk("cfg_err", cfg_err, x.err);
        if (x.c0_care)
            chk("clk_out_first_half", clk_out, x.c0);
        @(negedge clk_in);
        #1;
        chk("clk_out_second_half", clk_out, x.c1);
    endtask

    task automatic run_n(input int n);
        repeat (n) step(1, 0, 0);
    endtask

    task automatic run_to(input int target);
        int g = 0;
        while (m_cnt != target && g < 200) begin
            step(1, 0, 0);
            g++;
        end
        checks++;
        assert (g < 200) else begin
            failures++;
            $error("FAIL run_to_bound observed=%0d expected=%0d", m_cnt, target);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
        #1;
        chk("reset_clk_out", clk_out, 1'b0);
        chk("reset_rise", rise_tick, 1'b0);
        chk("reset_fall", fall_tick, 1'b0);
        chk("reset_pend", pend, 1'b0);
        chk("reset_cfg_err", cfg_err, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();

        // Default divisor 25
        run_n(60);

        // Rejected loads leave N=25 undisturbed
        step(1, 1, 1);
        step(1, 1, 0);
        run_n(5);

        // Load 4 mid-period; applies at the wrap
        run_to(10);
        step(1, 1, 4);
        run_n(40);

        // Odd N=3, then N=2
        step(1, 1, 3);
        run_n(20);
        step(1, 1, 2);
        run_n(12);

        // Back to 25, then overwrite a pending value with the same N
        step(1, 1, 25);
        run_to(3);
        step(1, 1, 9);
        step(1, 1, 25);
        run_n(30);

        // Load coinciding with the wrap edge
        run_to(24);
        step(1, 1, 4);
        run_n(35);
        step(1, 1, 25);
        run_n(10);

        // Enable dropped mid-period; a load while disabled applies next cycle
        run_to(10);
        step(0, 0, 0);
        step(0, 1, 25);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        run_n(30);

        // Async reset between edges with a pending load of 8
        step(1, 1, 8);
        run_to(6);
        en = 1'b1; div_load = 1'b0;
        @(posedge clk_in);
        #2;
        chk("pre_rst_clk_out", clk_out, 1'b1);
        chk("pre_rst_pend", pend, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_clk_out", clk_out, 1'b0);
        chk("async_rst_pend", pend, 1'b0);
        chk("async_rst_rise", rise_tick, 1'b0);
        @(posedge clk_in);
        #2;
        chk("held_rst_clk_out", clk_out, 1'b0);
        @(negedge clk_in);
        #1;
        rst = 1'b0;
        model_reset();
        run_n(55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable clock divider that generates a 50%-duty clk_out from clk_in for any integer divisor N ≥ 2, odd or even. Odd divisors use a negedge half-cycle extension. Also emits clk_in-domain rise/fall strobes so the I2C functional model can run SCL/SDA sequencing on clk_in with clock enables instead of on clk_out. Replaces fixed-ratio dividers; divisor changes apply glitch-free at a period boundary.

Parameters:
CNT_W, 16, width of the divisor and the period counter
DIV_DEFAULT, 25, active divisor after reset; must satisfy 2 ≤ DIV_DEFAULT ≤ 2^CNT_W−1

Ports:
clk_in  in  1  input clock; all state is on posedge, except the odd-N extension flop on negedge
rst  in  1  asynchronous, active-high reset
en  in  1  divider enable
div_val  in  CNT_W  requested divisor N
div_load  in  1  one-cycle strobe; samples div_val
clk_out  out  1  divided clock, 50% duty
rise_tick  out  1  one clk_in-cycle strobe marking the clk_out rising period
fall_tick  out  1  one clk_in-cycle strobe marking the clk_out falling period
pend  out  1  shadow divisor waiting to be applied
cfg_err  out  1  one-cycle strobe; rejected load

Behaviour:
- Reset (async, takes effect immediately with no edge): count=0; active N=DIV_DEFAULT; shadow=DIV_DEFAULT; pend=0; clk_out=0 (posedge and negedge phase flops both cleared); rise_tick=fall_tick=cfg_err=0.
- Definitions: H = N>>1. count runs 0..N−1 while en=1, then wraps to 0.
- q_p: registered; high in exactly the clk_in cycles where count ∈ [0, H−1].
- q_n: q_p resampled on negedge clk_in.
- clk_out = q_p for even N; clk_out = q_p | q_n for odd N.
  - Even N: high H cycles, low H cycles.
  - Odd N: high H+0.5 cycles, low H+0.5 cycles.
- N=2: high 1 cycle, low 1 cycle. N=3: high 1.5 cycles, low 1.5 cycles.
- rise_tick is high in the cycles where count==0.
- fall_tick is high in the cycles where count==H.
  - Even N: clk_out falls at the posedge that starts that cycle.
  - Odd N: clk_out falls at the negedge within that cycle.
- Enable:
  - en=0 sampled: next cycle count=0, q_p=q_n=0, clk_out low, no ticks.
  - First posedge with en=1 sampled starts a fresh period: that cycle has count=0, clk_out high, and rise_tick=1.
  - Dropping en mid-period truncates the period; clk_out goes low within one cycle (odd N: q_n clears at the following negedge).
- Divisor load:
  - div_load with div_val ≥ 2: shadow←div_val; pend=1 from the next cycle.
  - div_load with div_val < 2: cfg_err=1 for one cycle; shadow and pend unchanged.
  - Applying the shadow: at the posedge where count==N−1 and en=1, active N←shadow, pend←0, count←0. The new period starts with the new N.
  - If en=0, the shadow is applied on the next cycle and pend clears.
  - A second div_load while pend=1 overwrites the shadow; only the last value is applied.
  - A div_load in the same cycle as a wrap: the wrap applies the old shadow, and the new value becomes pending.
- Loading the same N as the active N still sets pend; the divisor is re-applied at the wrap with no visible change.
- No combinational path from inputs to outputs except through the odd-mode OR of two flops.

Decomposition:
- Package clk_div_pkg: DIV_MIN=2, CNT_W default, DIV_DEFAULT, and the cfg_err cause constant.
- One sub-module, clk_div_cfg: holds shadow, pend, cfg_err, active N and the apply-at-wrap handshake.
- Top level: counter, q_p/q_n phase flops, ticks.

Test Plan:
1. Reset release, en=1, no load → clk_out period 25 clk_in cycles, high 12.5 / low 12.5; rise_tick every 25 cycles; fall_tick 12 cycles after each rise_tick.
2. At count=10 with N=25, load div_val=4 → pend=1; current period completes all 25 cycles; subsequent periods are 4 cycles (2 high / 2 low); pend=0 after the wrap.
3. Load div_val=1, then div_val=0 → cfg_err pulses one cycle each; N stays 25; pend stays 0; waveform undisturbed.
4. Load N=3, then N=2 → N=3: high 1.5 / low 1.5, rise_tick period 3. N=2: high 1 / low 1, rise_tick and fall_tick alternate every cycle.
5. en dropped at count=10, held low 5 cycles, re-raised → clk_out low within 1 cycle, no ticks while low; first enabled cycle has rise_tick=1, clk_out high, and a full 25-cycle period follows.
6. Assert rst between edges at count=7 (clk_out high), with a pending load of 8 → clk_out drops before the next clk_in edge; after release pend=0, N=25, count=0.
